// File: rtl/out_stage.sv
// Multi-channel PWM output stage: shared period counter, double-buffered duty registers,
// registered polarity-selectable pin drivers. Define OUT_STAGE_CENTER_ALIGNED_EN for up/down counting.
module out_stage #(
  parameter int NCH = 7,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          invert_polarity,
  input  logic [CW-1:0] period,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [CW-1:0] wr_data,
  output logic [NCH-1:0] opins,
  output logic          period_wrap
);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  period_act_q, period_act_d;
  logic [CW-1:0]  duty_shadow_q [NCH];
  logic [CW-1:0]  duty_shadow_d [NCH];
  logic [CW-1:0]  duty_act_q [NCH];
  logic [CW-1:0]  duty_act_d [NCH];
  logic [NCH-1:0] raw;
  logic [NCH-1:0] opins_q, opins_d;
  logic           wrap_q, wrap_d;
  logic           wrap_evt;
  logic           commit;
`ifdef OUT_STAGE_CENTER_ALIGNED_EN
  logic           down_q, down_d;
`endif

  // NOTE: combinational blocks assign every output a default first, so no latch is inferred.
`ifdef OUT_STAGE_CENTER_ALIGNED_EN
  always_comb begin
    wrap_evt = 1'b0;
    cnt_d    = cnt_q;
    down_d   = down_q;
    if (!en) begin
      cnt_d  = '0;
      down_d = 1'b0;
    end else if (down_q) begin
      if (cnt_q == '0) begin
        // Turn at the bottom; restart from 1 unless the period being committed is 0.
        wrap_evt = 1'b1;
        down_d   = 1'b0;
        cnt_d    = (period == '0) ? '0 : CW'(1);
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (cnt_q >= period_act_q) begin
      if (period_act_q == '0) begin
        wrap_evt = 1'b1;
        cnt_d    = '0;
      end else begin
        down_d = 1'b1;
        cnt_d  = cnt_q - 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
`else
  always_comb begin
    wrap_evt = en && (cnt_q == period_act_q);
    cnt_d    = (!en || wrap_evt) ? '0 : cnt_q + 1'b1;
  end
`endif

  always_comb begin
    commit       = !en || wrap_evt;
    wrap_d       = wrap_evt;
    period_act_d = commit ? period : period_act_q;
    for (int i = 0; i < NCH; i++) begin
      // Commit sees the shadow before any same-cycle write lands.
      duty_act_d[i]    = commit ? duty_shadow_q[i] : duty_act_q[i];
      duty_shadow_d[i] = duty_shadow_q[i];
      if (wr_en && (wr_addr == 3'(i))) duty_shadow_d[i] = wr_data;
      raw[i] = en && (cnt_q < duty_act_q[i]);
    end
    opins_d = raw ^ {NCH{invert_polarity}};
  end

  // NOTE: the duty arrays are small flop banks, so they are reset like any other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      period_act_q <= '0;
      opins_q      <= '0;
      wrap_q       <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        duty_shadow_q[i] <= '0;
        duty_act_q[i]    <= '0;
      end
`ifdef OUT_STAGE_CENTER_ALIGNED_EN
      down_q       <= 1'b0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      period_act_q <= period_act_d;
      opins_q      <= opins_d;
      wrap_q       <= wrap_d;
      for (int i = 0; i < NCH; i++) begin
        duty_shadow_q[i] <= duty_shadow_d[i];
        duty_act_q[i]    <= duty_act_d[i];
      end
`ifdef OUT_STAGE_CENTER_ALIGNED_EN
      down_q       <= down_d;
`endif
    end
  end

  assign opins       = opins_q;
  assign period_wrap = wrap_q;

endmodule
